// File: rtl/picorv32_regs_ctrl_if.sv
// Request/response bundle between the core, the debug port and the
// register-file controller. The master modport is the requester side
// (core pipeline / debug module); the slave modport is the controller.
interface picorv32_regs_ctrl_if #(
    parameter int ADDR_W = 5
);
    // core read port (rs1 and rs2 issued together)
    logic              core_rd_valid;
    logic [ADDR_W-1:0] core_rs1;
    logic [ADDR_W-1:0] core_rs2;
    logic              core_rdata_valid;
    logic [31:0]       core_rs1_data;
    logic [31:0]       core_rs2_data;

    // core writeback port
    logic              core_wr_valid;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [31:0]       core_wr_data;
    logic              core_wr_ready;

    // debug access port
    logic              dbg_valid;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;

    modport master (
        output core_rd_valid, core_rs1, core_rs2,
        input  core_rdata_valid, core_rs1_data, core_rs2_data,
        output core_wr_valid, core_wr_addr, core_wr_data,
        input  core_wr_ready,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata
    );

    modport slave (
        input  core_rd_valid, core_rs1, core_rs2,
        output core_rdata_valid, core_rs1_data, core_rs2_data,
        input  core_wr_valid, core_wr_addr, core_wr_data,
        output core_wr_ready,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata
    );
endinterface

// File: rtl/picorv32_regs_ctrl.sv
// Register-file sequencer and port arbiter in front of a 32x32 2R1W
// synchronous BRAM with read-old-data behaviour.
//  - After reset the whole file is swept to zero (one entry per cycle).
//  - Core reads always win read port A1/A2; debug reads borrow A1 when the
//    core is not reading.
//  - Core writeback has fixed priority on the single write port; debug
//    writes take it when the core is not writing.
//  - x0 is never written and always reads as zero.
//  - A write issued in the same cycle as a read of the same register is
//    forwarded, hiding the BRAM's read-old-data behaviour.
// Optional feature macro: DEBUG_PORT_EN (undefined -> debug port inert,
// all debug outputs tied to zero, A1 dedicated to the core).
`default_nettype none

module picorv32_regs_ctrl #(
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              init_busy,
    picorv32_regs_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] rf_a1addr,
    output logic [ADDR_W-1:0] rf_a2addr,
    input  logic [31:0]       rf_a1data,
    input  logic [31:0]       rf_a2data,
    output logic [ADDR_W-1:0] rf_b1addr,
    output logic [31:0]       rf_b1data,
    output logic              rf_b1en
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Read data seen by a requester: x0 is hard zero, a write issued in the
    // same cycle as the read is forwarded, otherwise the BRAM output is used.
    function automatic logic [31:0] fwd_data(
        input logic [ADDR_W-1:0] rd_addr,
        input logic [31:0]       bram_data,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [31:0]       wr_data
    );
        logic [31:0] res;
        if (rd_addr == ADDR_ZERO) begin
            res = 32'h0000_0000;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            res = wr_data;
        end else begin
            res = bram_data;
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;

    logic              run_s;
    logic              clr_s;
    logic              core_rd_acc_s;
    logic              core_wr_acc_s;
    logic              dbg_rd_acc_s;
    logic              dbg_wr_acc_s;

    // Last issued read addresses: held on the BRAM when idle and also the
    // address each response in the following cycle belongs to.
    logic [ADDR_W-1:0] a1_addr_r;
    logic [ADDR_W-1:0] a2_addr_r;
    logic              core_rv_r;
    logic              dbg_rv_r;

    // Copy of the write issued last cycle, used for forwarding.
    logic              byp_en_r;
    logic [ADDR_W-1:0] byp_addr_r;
    logic [31:0]       byp_data_r;

    // Requests are only honoured in RUN while reset is not being asserted.
    assign run_s = (state_r == ST_RUN) && resetn;
    assign clr_s = (state_r == ST_CLEAR) && resetn;

    assign core_rd_acc_s = run_s && bus.core_rd_valid;
    assign core_wr_acc_s = run_s && bus.core_wr_valid;

`ifdef DEBUG_PORT_EN
    // Debug loses to the core on both the read and the write side.
    assign dbg_wr_acc_s = run_s && bus.dbg_valid && bus.dbg_we  && !bus.core_wr_valid;
    assign dbg_rd_acc_s = run_s && bus.dbg_valid && !bus.dbg_we && !bus.core_rd_valid;
`else
    logic unused_dbg_s;
    assign unused_dbg_s = ^{bus.dbg_valid, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
    assign dbg_wr_acc_s = 1'b0;
    assign dbg_rd_acc_s = 1'b0;
`endif

    // Sequencer state and sweep counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_CLEAR;
            cnt_r   <= ADDR_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state: sweep one entry per cycle, then stay in RUN until reset.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = ADDR_ZERO;
                end else begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = cnt_r + ADDR_ONE;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = cnt_r;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = ADDR_ZERO;
            end
        endcase
    end

    // Write port mux: sweep zeros, else core writeback, else debug write.
    always_comb begin
        rf_b1en   = 1'b0;
        rf_b1addr = ADDR_ZERO;
        rf_b1data = 32'h0000_0000;
        if (clr_s) begin
            rf_b1en   = 1'b1;
            rf_b1addr = cnt_r;
            rf_b1data = 32'h0000_0000;
        end else if (core_wr_acc_s) begin
            rf_b1en   = (bus.core_wr_addr != ADDR_ZERO);
            rf_b1addr = bus.core_wr_addr;
            rf_b1data = bus.core_wr_data;
        end else if (dbg_wr_acc_s) begin
            rf_b1en   = (bus.dbg_addr != ADDR_ZERO);
            rf_b1addr = bus.dbg_addr;
            rf_b1data = bus.dbg_wdata;
        end else begin
            rf_b1en   = 1'b0;
            rf_b1addr = ADDR_ZERO;
            rf_b1data = 32'h0000_0000;
        end
    end

    // Read address mux: core owns both ports, debug borrows A1, idle holds.
    always_comb begin
        rf_a1addr = a1_addr_r;
        rf_a2addr = a2_addr_r;
        if (core_rd_acc_s) begin
            rf_a1addr = bus.core_rs1;
            rf_a2addr = bus.core_rs2;
        end else if (dbg_rd_acc_s) begin
            rf_a1addr = bus.dbg_addr;
            rf_a2addr = a2_addr_r;
        end else begin
            rf_a1addr = a1_addr_r;
            rf_a2addr = a2_addr_r;
        end
    end

    // Response tracking and forwarding registers; reset drops any response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a1_addr_r  <= ADDR_ZERO;
            a2_addr_r  <= ADDR_ZERO;
            core_rv_r  <= 1'b0;
            dbg_rv_r   <= 1'b0;
            byp_en_r   <= 1'b0;
            byp_addr_r <= ADDR_ZERO;
            byp_data_r <= 32'h0000_0000;
        end else begin
            a1_addr_r  <= rf_a1addr;
            a2_addr_r  <= rf_a2addr;
            core_rv_r  <= core_rd_acc_s;
            dbg_rv_r   <= dbg_rd_acc_s;
            byp_en_r   <= rf_b1en;
            byp_addr_r <= rf_b1addr;
            byp_data_r <= rf_b1data;
        end
    end

    assign init_busy          = (state_r == ST_CLEAR);
    assign bus.core_wr_ready  = core_wr_acc_s;
    assign bus.core_rdata_valid = core_rv_r;

    // Core read data, zero whenever no response is being presented.
    always_comb begin
        bus.core_rs1_data = 32'h0000_0000;
        bus.core_rs2_data = 32'h0000_0000;
        if (core_rv_r) begin
            bus.core_rs1_data = fwd_data(a1_addr_r, rf_a1data, byp_en_r, byp_addr_r, byp_data_r);
            bus.core_rs2_data = fwd_data(a2_addr_r, rf_a2data, byp_en_r, byp_addr_r, byp_data_r);
        end else begin
            bus.core_rs1_data = 32'h0000_0000;
            bus.core_rs2_data = 32'h0000_0000;
        end
    end

`ifdef DEBUG_PORT_EN
    assign bus.dbg_ready  = dbg_wr_acc_s || dbg_rd_acc_s;
    assign bus.dbg_rvalid = dbg_rv_r;

    // Debug read data comes from port A1, zero when no response is due.
    always_comb begin
        bus.dbg_rdata = 32'h0000_0000;
        if (dbg_rv_r) begin
            bus.dbg_rdata = fwd_data(a1_addr_r, rf_a1data, byp_en_r, byp_addr_r, byp_data_r);
        end else begin
            bus.dbg_rdata = 32'h0000_0000;
        end
    end
`else
    logic unused_dbg_rv_s;
    assign unused_dbg_rv_s = dbg_rv_r;
    assign bus.dbg_ready   = 1'b0;
    assign bus.dbg_rvalid  = 1'b0;
    assign bus.dbg_rdata   = 32'h0000_0000;
`endif

endmodule

`default_nettype wire
